// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types and constants for the MCP4921-class DAC SPI serializer.
//   state_t          FSM states of the frame sequencer
//   FRAME_BITS       SPI write frame width (header + sample)
//   BIT_W            width of the bit index within a frame
//   CFG_BITS_DEFAULT header nibble: channel A, buffered, 1x gain, active
//   CS_LOW_PERIODS   half-periods with chip select low (SETUP + 32 SHIFT + HOLD)
//   frame_cycles()   system clocks from accept to frame_done; depends on DAC_LDAC_PULSE_EN
package dac_spi_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    LDAC  = 3'd5
  } state_t;
  localparam int FRAME_BITS = 16;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0111;
  localparam int CS_LOW_PERIODS = 2 * FRAME_BITS + 2;
  function automatic int frame_cycles(input int clk_div);
`ifdef DAC_LDAC_PULSE_EN
    return (CS_LOW_PERIODS + 2) * clk_div;
`else
    return (CS_LOW_PERIODS + 1) * clk_div;
`endif
  endfunction
endpackage

// File: rtl/dac_spi_serializer_timer.sv
// spi_phase_timer: CLK_DIV phase counter that paces the SPI sequencer.
//   clk, rst     system clock, asynchronous active-high reset
//   en           sequencer is outside IDLE; counter is held at zero otherwise
//   shift        sequencer is in SHIFT; only then do phase and bit index advance
//   half_tick    last cycle of the current CLK_DIV-long half-period
//   phase        current SCLK level within the bit (0 low half, 1 high half)
//   bit_idx      current bit of the frame, 0 = MSB
//   phase_nxt    value phase takes after this clock (lets outputs be registered with no lag)
//   bit_nxt      value bit_idx takes after this clock
module spi_phase_timer
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             shift,
  output logic             half_tick,
  output logic             phase,
  output logic             phase_nxt,
  output logic [BIT_W-1:0] bit_idx,
  output logic [BIT_W-1:0] bit_nxt
);
  logic [7:0] cnt;
  assign half_tick = en && cnt == 8'(CLK_DIV - 1);
  assign phase_nxt = en && ((shift && half_tick) ? !phase : phase);
  assign bit_nxt = !en ? '0 : (shift && half_tick && phase) ? bit_idx + 1'b1 : bit_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      phase <= 1'b0;
      bit_idx <= '0;
    end else begin
      cnt <= (!en || half_tick) ? 8'd0 : cnt + 8'd1;
      phase <= phase_nxt;
      bit_idx <= bit_nxt;
    end
endmodule

// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: serializes 12-bit samples into 16-bit SPI frames for an MCP4921-class DAC.
//   clk           125 MHz system clock
//   rst           asynchronous active-high reset; SPI pins go idle immediately
//   sample_in     offset-binary sample, taken on sample_valid
//   sample_valid  single-cycle strobe; one-deep pending buffer while busy
//   busy          frame in progress (cycle after accept through last frame cycle)
//   frame_done    one-cycle pulse on the first IDLE cycle after a frame
//   drop_count    saturating count of overwritten/discarded pending samples
//   dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n   SPI mode 0, MSB first
// Build option DAC_LDAC_PULSE_EN: when defined an LDAC state pulses dac_ldac_n low for
// CLK_DIV cycles after GAP; otherwise dac_ldac_n is tied low and the DAC latches on cs_n rising.
module dac_spi_serializer
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter int         DAC_BITS = 12,
  parameter logic [3:0] CFG_BITS = CFG_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DAC_BITS-1:0] sample_in,
  input  logic                sample_valid,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          drop_count,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                dac_ldac_n
);
  state_t state, state_n;
  logic [FRAME_BITS-1:0] frame, frame_nxt;
  logic [DAC_BITS-1:0] pend;
  logic pend_full;
  logic half_tick, phase, phase_nxt;
  logic [BIT_W-1:0] bit_idx, bit_nxt;
  logic cs_n_d, sclk_d, mosi_d, busy_d, done_d;
  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (state != IDLE),
    .shift     (state == SHIFT),
    .half_tick (half_tick),
    .phase     (phase),
    .phase_nxt (phase_nxt),
    .bit_idx   (bit_idx),
    .bit_nxt   (bit_nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (sample_valid || pend_full) ? SETUP : IDLE;
      SETUP:   state_n = half_tick ? SHIFT : SETUP;
      SHIFT:   state_n = (half_tick && phase && bit_idx == BIT_W'(FRAME_BITS - 1)) ? HOLD : SHIFT;
      HOLD:    state_n = half_tick ? GAP : HOLD;
`ifdef DAC_LDAC_PULSE_EN
      GAP:     state_n = half_tick ? LDAC : GAP;
      LDAC:    state_n = half_tick ? IDLE : LDAC;
`else
      GAP:     state_n = half_tick ? IDLE : GAP;
`endif
      default: state_n = IDLE;
    endcase
  end
  // A fresh strobe in IDLE beats a pending sample; the pending one is then counted as dropped.
  assign frame_nxt = (state == IDLE && sample_valid) ? {CFG_BITS, sample_in} :
                     (state == IDLE && pend_full)    ? {CFG_BITS, pend} : frame;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frame <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      frame <= frame_nxt;
      pend <= (state != IDLE && sample_valid) ? sample_in : pend;
      pend_full <= state != IDLE && (pend_full || sample_valid);
      drop_count <= (sample_valid && pend_full && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
    end
  // Outputs are decoded from next-state/next-phase and registered, so pins match the state register.
  always_comb begin
    cs_n_d = !(state_n == SETUP || state_n == SHIFT || state_n == HOLD);
    sclk_d = state_n == SHIFT && phase_nxt;
    mosi_d = (state_n == SETUP || state_n == SHIFT) && frame_nxt[BIT_W'(FRAME_BITS - 1) - bit_nxt];
    busy_d = state_n != IDLE;
    done_d = state_n == IDLE && state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dac_cs_n <= 1'b1;
      dac_sclk <= 1'b0;
      dac_mosi <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dac_cs_n <= cs_n_d;
      dac_sclk <= sclk_d;
      dac_mosi <= mosi_d;
      busy <= busy_d;
      frame_done <= done_d;
    end
`ifdef DAC_LDAC_PULSE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) dac_ldac_n <= 1'b1;
    else dac_ldac_n <= state_n != LDAC;
`else
  assign dac_ldac_n = 1'b0;
`endif
endmodule

// File: tb/tb_dac_spi_serializer.sv
// tb_dac_spi_serializer: scoreboard bench; stimulus pushes expected frames, a monitor decodes SPI and pops.
module tb_dac_spi_serializer;
  import dac_spi_pkg::*;
  localparam int DIV = 4;
  localparam int FRAME_LEN = frame_cycles(DIV);
`ifdef DAC_LDAC_PULSE_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
  logic [11:0] sample_in = '0;
  logic busy, frame_done, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n;
  logic [7:0] drop_count;
  int errors = 0, checks = 0, cyc = 0, last_acc = 0, ldac_bad = 0;
  logic [15:0] exp_q[$];
  dac_spi_serializer #(.CLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .drop_count   (drop_count),
    .dac_cs_n     (dac_cs_n),
    .dac_sclk     (dac_sclk),
    .dac_mosi     (dac_mosi),
    .dac_ldac_n   (dac_ldac_n)
  );
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [11:0] v, input bit chk);
    sample_in = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    last_acc = cyc;
    if (chk) begin
      check("cs_fall_next_cycle", int'(dac_cs_n), 0);
      check("busy_after_accept", int'(busy), 1);
    end
  endtask
  task automatic wait_done(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 1000);
    if (!frame_done) check("frame_done_timeout", 0, 1);
    c = cyc;
  endtask
  // Monitor: shifts mosi on rising sclk while cs_n is low, compares at cs_n rising.
  logic in_frame = 1'b0, prev_sclk = 1'b0;
  logic [15:0] word;
  int nbits, cs_len, ldac_len = 0;
  always @(negedge clk) begin
    if (rst) in_frame = 1'b0;
    else if (!dac_cs_n) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        nbits = 0;
        cs_len = 0;
        word = '0;
      end
      cs_len++;
      if (dac_sclk && !prev_sclk) begin
        word = {word[14:0], dac_mosi};
        nbits++;
      end
    end else if (in_frame) begin
      in_frame = 1'b0;
      if (exp_q.size() == 0) check("unexpected_frame", int'(word), -1);
      else begin
        check("frame_word", int'(word), int'(exp_q.pop_front()));
        check("frame_bits", nbits, FRAME_BITS);
        check("cs_low_cycles", cs_len, CS_LOW_PERIODS * DIV);
      end
    end
    prev_sclk = dac_sclk;
`ifdef DAC_LDAC_PULSE_EN
    if (!dac_ldac_n) ldac_len++;
    else if (ldac_len != 0) begin
      check("ldac_low_cycles", ldac_len, DIV);
      ldac_len = 0;
    end
`else
    if (dac_ldac_n !== 1'b0) ldac_bad++;
`endif
  end
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    int c, t;
    repeat (3) tick();
    check("rst_cs_n", int'(dac_cs_n), 1);
    check("rst_sclk", int'(dac_sclk), 0);
    check("rst_mosi", int'(dac_mosi), 0);
    check("rst_ldac_n", int'(dac_ldac_n), int'(LDAC_IDLE));
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_drop", int'(drop_count), 0);
    rst = 1'b0;
    repeat (2) tick();
    // single frame
    exp_q.push_back(16'h7ABC);
    strobe(12'hABC, 1);
    t = last_acc;
    wait_done(c);
    check("frame_latency", c - t, FRAME_LEN);
    repeat (5) tick();
    // slow ramp, no overlap
    for (int i = 0; i < 16; i++) begin
      check("busy_at_strobe", int'(busy), 0);
      exp_q.push_back({4'h7, 12'(i * 273)});
      strobe(12'(i * 273), 1);
      repeat (297) tick();
    end
    check("ramp_drop", int'(drop_count), 0);
    // three strobes 10 cycles apart: middle one overwritten
    exp_q.push_back(16'h7111);
    exp_q.push_back(16'h7333);
    strobe(12'h111, 1);
    repeat (9) tick();
    strobe(12'h222, 0);
    repeat (9) tick();
    strobe(12'h333, 0);
    wait_done(c);
    tick();
    check("pending_starts_next_cycle", int'(dac_cs_n), 0);
    wait_done(c);
    check("overwrite_drop", int'(drop_count), 1);
    repeat (5) tick();
    // strobe in the cycle the pending sample would be consumed
    exp_q.push_back(16'h7111);
    exp_q.push_back(16'h7555);
    strobe(12'h111, 1);
    t = last_acc;
    repeat (9) tick();
    strobe(12'h222, 0);
    while (cyc < t + FRAME_LEN) tick();
    check("consume_cycle_done", int'(frame_done), 1);
    strobe(12'h555, 1);
    wait_done(c);
    check("collision_latency", c - last_acc, FRAME_LEN);
    check("collision_drop", int'(drop_count), 2);
    repeat (2) tick();
    check("pending_discarded", int'(busy), 0);
    // reset mid-frame
    exp_q.push_back(16'h7123);
    strobe(12'h123, 1);
    repeat (60) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_cs_n", int'(dac_cs_n), 1);
    check("midrst_sclk", int'(dac_sclk), 0);
    check("midrst_ldac_n", int'(dac_ldac_n), int'(LDAC_IDLE));
    check("midrst_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("midrst_drop", int'(drop_count), 0);
    exp_q.push_back(16'h7456);
    strobe(12'h456, 1);
    t = last_acc;
    wait_done(c);
    check("post_rst_latency", c - t, FRAME_LEN);
    repeat (3) tick();
    // 300 consecutive strobes: four frames go out, drops saturate
    repeat (4) exp_q.push_back(16'h70FF);
    sample_in = 12'h0FF;
    sample_valid = 1'b1;
    repeat (300) tick();
    sample_valid = 1'b0;
    repeat (400) tick();
    check("drop_saturated", int'(drop_count), 255);
    check("overrun_idle", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
`ifndef DAC_LDAC_PULSE_EN
    check("ldac_tied_low", ldac_bad, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
